// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronises rx, qualifies the start bit at mid-bit and samples data and stop bits at bit centres.
// Good bytes appear on data_Byte with a one-cycle Rx_done; a low stop bit gives a one-cycle frame_err and drops the byte.
module uart_byte_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int BAUD_DIV = CLK_FREQ / BAUD,
    parameter int HALF     = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_Byte,
    output logic       Rx_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic             sync_1;
    logic             sync_2;
    logic             rx_prev;
    logic             rx_s;
    logic             start_edge;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             cnt_last;
    logic             half_last;

    assign rx_s       = sync_2;
    // A falling edge, not a low level, starts a frame so a held-low line cannot retrigger.
    assign start_edge = rx_prev & ~rx_s;
    assign cnt_last   = (cnt == DIV_LAST);
    assign half_last  = (cnt == HALF_LAST);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1  <= 1'b1;
            sync_2  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_1  <= rx;
            sync_2  <= sync_1;
            rx_prev <= sync_2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data_Byte <= '0;
            Rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            Rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (half_last) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (cnt_last) begin
                        shift   <= {rx_s, shift[7:1]};
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    // Leaving at the stop-bit centre leaves half a bit to see the next start edge.
                    if (cnt_last) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                        if (rx_s) begin
                            data_Byte <= shift;
                            Rx_done   <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at default parameters: table of single frames plus hand-written
// sequences for timing, back-to-back, framing error, glitch and mid-frame reset.
module tb_uart_byte_rx;

    localparam int BIT  = 434;
    localparam int HALF = 217;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_Byte;
    logic       Rx_done;
    logic       frame_err;
    logic       busy;

    uart_byte_rx dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_Byte (data_Byte),
        .Rx_done   (Rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    // Strobe monitor, sampled on the falling edge.
    int         n_done = 0;
    int         n_ferr = 0;
    logic [7:0] rx_q[$];
    int         last_done_cyc = 0;
    logic       busy_at_done = 1'b0;
    logic       busy_before_done = 1'b0;
    logic       prev_busy = 1'b0;
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;
    logic       both_seen = 1'b0;
    logic       long_seen = 1'b0;

    always @(negedge clk) begin
        if (Rx_done === 1'b1) begin
            n_done++;
            rx_q.push_back(data_Byte);
            last_done_cyc    = cyc;
            busy_at_done     = busy;
            busy_before_done = prev_busy;
        end
        if (frame_err === 1'b1) n_ferr++;
        if (Rx_done === 1'b1 && frame_err === 1'b1) both_seen = 1'b1;
        if ((Rx_done === 1'b1 && prev_done) || (frame_err === 1'b1 && prev_ferr)) long_seen = 1'b1;
        prev_busy = busy;
        prev_done = Rx_done;
        prev_ferr = frame_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int start_cyc = 0;

    task automatic send_frame(input logic [7:0] d, input logic stop, input int p);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 rx = bits[i];
            if (i == 0) start_cyc = cyc;
            repeat (p - 1) @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         period;
        int         exp_done;
        int         exp_ferr;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[3];

    int         d0;
    int         f0;
    int         bad;
    logic [7:0] str_bytes[9];
    logic [9:0] fbits;

    initial begin
        vecs[0] = '{8'h2B, 1'b1, 451, 1, 0, 8'h2B};
        vecs[1] = '{8'h2B, 1'b1, 417, 1, 0, 8'h2B};
        vecs[2] = '{8'hFF, 1'b1, 434, 1, 0, 8'hFF};

        str_bytes = '{8'h2B, 8'h53, 8'h50, 8'h4F, 8'h32, 8'h3D, 8'h39, 8'h38, 8'h0D};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data_Byte, 8'h00);
        check("rst_done", Rx_done, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Idle line: nothing happens
        bad = 0;
        repeat (3000) begin
            @(negedge clk);
            if (busy !== 1'b0 || Rx_done !== 1'b0 || frame_err !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);
        check("idle_data", data_Byte, 8'h00);

        // 0x2B at defaults with exact latency
        d0 = n_done;
        f0 = n_ferr;
        send_frame(8'h2B, 1'b1, BIT);
        idle(10);
        check("t2b_count", n_done - d0, 1);
        check("t2b_ferr", n_ferr - f0, 0);
        check("t2b_data", data_Byte, 8'h2B);
        check("t2b_latency", last_done_cyc - start_cyc, 4126);
        check("t2b_busy_at_done", busy_at_done, 1'b0);
        check("t2b_busy_before", busy_before_done, 1'b1);

        // Table of single frames
        for (int i = 0; i < 3; i++) begin
            idle(40);
            d0 = n_done;
            f0 = n_ferr;
            send_frame(vecs[i].d, vecs[i].stop, vecs[i].period);
            idle(10);
            check($sformatf("vec%0d_done", i), n_done - d0, vecs[i].exp_done);
            check($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_data", i), data_Byte, vecs[i].exp_byte);
        end

        // "+SPO2=98\r" back-to-back
        idle(40);
        rx_q.delete();
        d0 = n_done;
        f0 = n_ferr;
        for (int i = 0; i < 9; i++) send_frame(str_bytes[i], 1'b1, BIT);
        idle(20);
        check("str_count", n_done - d0, 9);
        check("str_ferr", n_ferr - f0, 0);
        for (int i = 0; i < 9; i++) begin
            if (rx_q.size() > 0) check($sformatf("str_byte%0d", i), rx_q.pop_front(), str_bytes[i]);
            else check($sformatf("str_byte%0d", i), 32'hFFFF_FFFF, str_bytes[i]);
        end

        // Framing error then low hold then good byte
        idle(40);
        d0 = n_done;
        f0 = n_ferr;
        send_frame(8'h55, 1'b0, BIT);
        check("fe_ferr", n_ferr - f0, 1);
        check("fe_done", n_done - d0, 0);
        check("fe_data_held", data_Byte, 8'h0D);
        bad = 0;
        repeat (3 * BIT) begin
            @(negedge clk);
            if (busy !== 1'b0 || Rx_done !== 1'b0 || frame_err !== 1'b0) bad++;
        end
        check("fe_hold_quiet", bad, 0);
        idle(40);
        d0 = n_done;
        f0 = n_ferr;
        send_frame(8'h41, 1'b1, BIT);
        idle(10);
        check("fe_next_done", n_done - d0, 1);
        check("fe_next_ferr", n_ferr - f0, 0);
        check("fe_next_data", data_Byte, 8'h41);

        // 100-cycle glitch then 0xA5
        idle(40);
        d0 = n_done;
        f0 = n_ferr;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (100) @(posedge clk);
        #1 rx = 1'b1;
        repeat (HALF + 10) @(posedge clk);
        #1;
        check("gl_busy", busy, 1'b0);
        check("gl_strobes", (n_done - d0) + (n_ferr - f0), 0);
        send_frame(8'hA5, 1'b1, BIT);
        idle(10);
        check("gl_next_done", n_done - d0, 1);
        check("gl_next_data", data_Byte, 8'hA5);

        // Reset midway through data bit 4 of 0xF0
        idle(40);
        d0 = n_done;
        f0 = n_ferr;
        fbits = {1'b1, 8'hF0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 rx = fbits[i];
            repeat ((i == 4) ? HALF - 1 : BIT - 1) @(posedge clk);
        end
        #1;
        check("mr_busy_before", busy, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        rx = 1'b1;
        #1;
        check("mr_data", data_Byte, 8'h00);
        check("mr_busy", busy, 1'b0);
        check("mr_done", Rx_done, 1'b0);
        check("mr_ferr", frame_err, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (500) @(posedge clk);
        check("mr_no_strobe", (n_done - d0) + (n_ferr - f0), 0);
        send_frame(8'h0F, 1'b1, BIT);
        idle(10);
        check("mr_next_done", n_done - d0, 1);
        check("mr_next_data", data_Byte, 8'h0F);

        check("never_both", both_seen, 1'b0);
        check("one_cycle_strobes", long_seen, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
